// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with a small byte FIFO
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_start,
    output logic                          txd,
    output logic                          tx_busy,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_overflow
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW  = PW + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            tick;
    logic            full;
    logic            push;
    logic            pop;

    assign tick = (baud_q == BAUD_LAST);
    assign full = (level_q == LEVEL_MAX);
    // A push seen while full is refused even when a pop frees a slot this edge.
    assign push = tx_start && !full;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    baud_d = '0;
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ovf_d = tx_start && full;
    end

    // The line level is computed from the next state so txd changes on the same edge.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign txd         = txd_q;
    assign tx_busy     = (state_q != IDLE) || (level_q != '0);
    assign tx_full     = full;
    assign tx_level    = level_q;
    assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo at DIV=10, depth 4
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int DIV      = CLK_FREQ / BAUD;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       txd;
    logic       tx_busy;
    logic       tx_full;
    logic [2:0] tx_level;
    logic       tx_overflow;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .txd         (txd),
        .tx_busy     (tx_busy),
        .tx_full     (tx_full),
        .tx_level    (tx_level),
        .tx_overflow (tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int edge_n = 0;

    // Reference: a frame occupies 10*DIV edges from its pop; a new pop may
    // happen at any edge at or after the previous frame's end.
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         frame_start = 0;
    int         frame_end   = 0;
    logic       m_ovf = 1'b0;

    typedef struct {
        logic       r;
        logic       s;
        logic [7:0] d;
        int         n;
        logic       e_txd;
        logic       e_busy;
        int         e_level;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    endtask

    function automatic logic model_txd();
        int k;
        if (edge_n >= frame_end) return 1'b1;
        k = (edge_n - frame_start) / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    task automatic step(input logic r, input logic s, input logic [7:0] d);
        int sz;
        rst = r; tx_start = s; tx_data = d;
        @(posedge clk);
        edge_n++;
        if (r) begin
            q.delete();
            frame_end = edge_n;
            m_ovf = 1'b0;
        end else begin
            sz = q.size();
            m_ovf = s && (sz == DEPTH);
            if (sz > 0 && edge_n >= frame_end) begin
                cur = q.pop_front();
                frame_start = edge_n;
                frame_end = edge_n + 10 * DIV;
            end
            if (s && sz < DEPTH) q.push_back(d);
        end
        #1;
        rst = 1'b0; tx_start = 1'b0;
        chk("model_txd", int'(txd), int'(model_txd()));
        chk("model_busy", int'(tx_busy), int'((edge_n < frame_end) || (q.size() > 0)));
        chk("model_level", int'(tx_level), q.size());
        chk("model_full", int'(tx_full), int'(q.size() == DEPTH));
        chk("model_ovf", int'(tx_overflow), int'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (tx_busy && c < budget) begin
            step(1'b0, 1'b0, 8'h00);
            c++;
        end
        chk("drain_done", int'(tx_busy), 0);
    endtask

    initial begin
        int cnt;
        logic [7:0] d55;
        rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00;

        d55 = 8'h55;
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1,  1'b1, 1'b0, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 20, 1'b1, 1'b0, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h55, 1,  1'b1, 1'b1, 1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 10, 1'b0, 1'b1, 0, 1'b0, 1'b0});
        for (int b = 0; b < 8; b++)
            tbl.push_back('{1'b0, 1'b0, 8'h00, 10, d55[b], 1'b1, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 10, 1'b1, 1'b1, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 5,  1'b1, 1'b0, 0, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                step(tbl[i].r, tbl[i].s, tbl[i].d);
                chk("tbl_txd", int'(txd), int'(tbl[i].e_txd));
                chk("tbl_busy", int'(tx_busy), int'(tbl[i].e_busy));
                chk("tbl_level", int'(tx_level), tbl[i].e_level);
                chk("tbl_full", int'(tx_full), int'(tbl[i].e_full));
                chk("tbl_ovf", int'(tx_overflow), int'(tbl[i].e_ovf));
            end
        end

        // Back-to-back frames with no idle gap.
        step(1'b0, 1'b1, 8'hA3);
        step(1'b0, 1'b1, 8'h0F);
        chk("b2b_level_after_pop1", int'(tx_level), 1);
        idle(99);
        chk("b2b_level_stop", int'(tx_level), 1);
        chk("b2b_txd_stop", int'(txd), 1);
        step(1'b0, 1'b0, 8'h00);
        chk("b2b_level_pop2", int'(tx_level), 0);
        chk("b2b_txd_start2", int'(txd), 0);
        drain(150);

        // Overflow: six pushes into depth 4, five frames in exactly 500 cycles.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'(8'h30 + i));
            if (i == 4) chk("ovf_full_at5", int'(tx_full), 1);
        end
        chk("ovf_pulse", int'(tx_overflow), 1);
        chk("ovf_full", int'(tx_full), 1);
        step(1'b0, 1'b0, 8'h00);
        chk("ovf_one_cycle", int'(tx_overflow), 0);
        cnt = 1;
        while (tx_busy && cnt < 700) begin
            step(1'b0, 1'b0, 8'h00);
            cnt++;
        end
        chk("ovf_five_frames_len", cnt, 496);

        // Push and pop on the same edge with two bytes queued.
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        chk("pp_level_before", int'(tx_level), 2);
        idle(98);
        step(1'b0, 1'b1, 8'h44);
        chk("pp_level_same", int'(tx_level), 2);
        chk("pp_txd_start", int'(txd), 0);
        drain(400);

        // Reset in the middle of data bit 3 discards the frame and the queue.
        step(1'b0, 1'b1, 8'hC6);
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h3C);
        idle(41);
        step(1'b1, 1'b0, 8'h00);
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_level", int'(tx_level), 0);
        step(1'b0, 1'b1, 8'h01);
        drain(200);

        // Randomised traffic with bursty phases and rare resets.
        for (int i = 0; i < 4000; i++) begin
            int p;
            p = ((i / 500) % 2 == 1) ? 50 : 4;
            step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 99) < p), 8'($urandom));
        end
        drain(700);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter that serializes CPU store bytes onto the serial TxD line. A small byte FIFO sits between the CPU-side controller and the shift register, so a store to the UART data address is accepted in one cycle and does not stall the pipeline while the FIFO has space. Status outputs let the controller raise a pause request only when the FIFO is full, and let software poll for write-ready.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 9600, serial bit rate.
FIFO_DEPTH, 4, byte FIFO depth; must be a power of two and at least 2.
DIV (localparam), CLK_FREQ/BAUD with integer truncation, clock cycles per serial bit (5208 at defaults).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
tx_data  input  8  byte to transmit; sampled when tx_start is high.
tx_start  input  1  one-cycle push request.
txd  output  1  serial line; idle high.
tx_busy  output  1  high while a frame is in flight or the FIFO is non-empty.
tx_full  output  1  FIFO full; a push is refused while this is high.
tx_level  output  clog2(FIFO_DEPTH)+1  number of bytes currently queued, excluding the byte in the shift register.
tx_overflow  output  1  one-cycle pulse when tx_start arrives while tx_full is high.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered or decoded from registers.
- Reset values: txd=1, tx_busy=0, tx_full=0, tx_level=0, tx_overflow=0. FIFO pointers, bit counter and baud counter clear to 0. State goes to IDLE.
- Reset asserted mid-frame aborts the frame. txd returns to 1 on the next edge and queued bytes are discarded.
- Push: on an edge where tx_start=1 and tx_full=0, tx_data is written at the write pointer, and the write pointer and level increment. Pointers wrap modulo FIFO_DEPTH.
- Push while full: the push is refused even if a pop occurs on the same edge. The FIFO is unchanged and tx_overflow pulses for one cycle.
- Pop: allowed only at a frame boundary, i.e. in IDLE, or in STOP on the last baud cycle. Pop loads the shift register, increments the read pointer and decrements the level.
- Simultaneous push and pop (not full): the level is unchanged and both pointers advance.
- State machine:
  - IDLE: txd=1. If the FIFO is non-empty, pop, clear the baud counter and go to START.
  - START: txd=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for DIV cycles, then shift right and increment the bit index. After bit index 7 completes, go to STOP. Bits go out LSB first.
  - STOP: txd=1 for DIV cycles. On the last cycle, if the FIFO is non-empty, pop and go to START; otherwise go to IDLE. Back-to-back frames therefore have no gap beyond the single stop bit.
- Baud counter counts 0..DIV-1 and produces a bit tick at DIV-1. One frame is exactly 10*DIV cycles.
- Latency: with the FIFO empty and IDLE, tx_start is sampled at edge N, the pop happens at edge N+1, and txd=0 is visible after edge N+1.
- tx_busy = (state != IDLE) OR (level != 0). tx_full = (level == FIFO_DEPTH).
- txd is driven from a register so the line is glitch-free.

Test Plan:
- Reset, then hold 20 cycles with no stimulus → txd=1, tx_busy=0, tx_level=0, tx_full=0, tx_overflow=0 throughout.
- CLK_FREQ=1000, BAUD=100 (DIV=10); push 0x55 at edge N → txd=0 from edge N+1 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then stop bit 1 for 10 cycles. tx_busy falls 101 cycles after the push.
- DIV=10; push 0xA3 and 0x0F on consecutive cycles → two frames of 100 cycles each with no idle cycle between them. Data bits are 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0. tx_level reads 1 then 0 at the second pop.
- DIV=10; push 6 bytes on consecutive cycles with FIFO_DEPTH=4 → first byte goes to the shift register and the next 4 fill the FIFO. tx_full=1 at the 6th push, which pulses tx_overflow and is dropped. Exactly 5 frames are transmitted.
- Push and pop on the same edge, with the FIFO holding 2 bytes at the end of a stop bit → tx_level stays 2, the new byte lands behind the others, and order is preserved.
- Assert rst for 1 cycle in the middle of DATA bit 3 → txd=1 on the next edge, tx_busy=0, tx_level=0. A subsequent push of 0x01 transmits cleanly.
